keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Emulates one key of a 3x4 scanned keypad: on command it closes the matrix
// contact for a key with configurable press/release bounce, hold time and gap.
module keypad_emulator #(
  parameter int BOUNCE_LEN    = 16,
  parameter int BOUNCE_TOGGLE = 3,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [15:0] hold_cycles,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  press_count,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    GAP            = 3'd4
  } state_t;

  localparam bit          BOUNCE_EN = (BOUNCE_LEN > 0);
  localparam logic [15:0] BOUNCE_M1 = BOUNCE_EN ? 16'(BOUNCE_LEN - 1) : 16'd0;
  localparam logic [15:0] TOGGLE_M1 = 16'(BOUNCE_TOGGLE - 1);
  localparam logic [15:0] GAP_M1    = 16'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  code_q;
  logic [15:0] hold_q;
  logic [15:0] cnt_q;
  logic [15:0] tog_q;
  logic        phase_q;
  logic        err_q;
  logic [7:0]  press_count_q;

  logic [15:0] hold_d;
  logic        contact;
  logic [1:0]  col_bit;
  logic [1:0]  row_bit;

  // Hold length minus one; a request of zero still gives one closed cycle.
  assign hold_d = (hold_cycles == 16'd0) ? 16'd0 : hold_cycles - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      code_q        <= 4'd0;
      hold_q        <= 16'd0;
      cnt_q         <= 16'd0;
      tog_q         <= 16'd0;
      phase_q       <= 1'b0;
      err_q         <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      err_q <= 1'b0;
      if (state_q == PRESS_BOUNCE || state_q == RELEASE_BOUNCE) begin
        if (tog_q == TOGGLE_M1) begin
          tog_q   <= 16'd0;
          phase_q <= ~phase_q;
        end else begin
          tog_q <= tog_q + 16'd1;
        end
      end
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            code_q  <= key_code;
            hold_q  <= hold_d;
            tog_q   <= 16'd0;
            phase_q <= 1'b0;
            if (key_code > 4'hA) begin
              err_q <= 1'b1;
            end else if (BOUNCE_EN) begin
              state_q <= PRESS_BOUNCE;
              cnt_q   <= BOUNCE_M1;
            end else begin
              state_q <= HOLD;
              cnt_q   <= hold_d;
            end
          end
        end
        PRESS_BOUNCE: begin
          if (cnt_q == 16'd0) begin
            state_q <= HOLD;
            cnt_q   <= hold_q;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        HOLD: begin
          if (cnt_q != 16'd0) begin
            cnt_q <= cnt_q - 16'd1;
          end else if (BOUNCE_EN) begin
            state_q <= RELEASE_BOUNCE;
            cnt_q   <= BOUNCE_M1;
            tog_q   <= 16'd0;
            phase_q <= 1'b0;
          end else begin
            state_q <= GAP;
            cnt_q   <= GAP_M1;
          end
        end
        RELEASE_BOUNCE: begin
          if (cnt_q == 16'd0) begin
            state_q <= GAP;
            cnt_q   <= GAP_M1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == 16'd0) begin
            state_q       <= IDLE;
            press_count_q <= press_count_q + 8'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Press bounce starts closed, release bounce starts open.
  always_comb begin
    contact = 1'b0;
    case (state_q)
      PRESS_BOUNCE:   contact = ~phase_q;
      HOLD:           contact = 1'b1;
      RELEASE_BOUNCE: contact = phase_q;
      default:        contact = 1'b0;
    endcase
  end

  // Bit positions: col0/row0 live in bit 3.
  always_comb begin
    col_bit = 2'd0;
    row_bit = 2'd3;
    case (code_q)
      4'h1: begin col_bit = 2'd3; row_bit = 2'd3; end
      4'h4: begin col_bit = 2'd3; row_bit = 2'd2; end
      4'h7: begin col_bit = 2'd3; row_bit = 2'd1; end
      4'h2: begin col_bit = 2'd2; row_bit = 2'd3; end
      4'h5: begin col_bit = 2'd2; row_bit = 2'd2; end
      4'h8: begin col_bit = 2'd2; row_bit = 2'd1; end
      4'h0: begin col_bit = 2'd2; row_bit = 2'd0; end
      4'h3: begin col_bit = 2'd1; row_bit = 2'd3; end
      4'h6: begin col_bit = 2'd1; row_bit = 2'd2; end
      4'h9: begin col_bit = 2'd1; row_bit = 2'd1; end
      4'hA: begin col_bit = 2'd1; row_bit = 2'd0; end
      default: begin col_bit = 2'd0; row_bit = 2'd3; end
    endcase
  end

  always_comb begin
    row_out = 4'b1111;
    if (contact && !col_in[col_bit]) row_out[row_bit] = 1'b0;
  end

  assign key_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == GAP) && (cnt_q == 16'd0);
  assign err         = err_q;
  assign press_count = press_count_q;
  assign dbg_state_o = state_q;

endmodule
